data_mem_arbiter: RTL

//  Shares one single-port DataMemory-class word RAM between two requesters: port 0
//  (CPU load/store stage) and port 1 (DMA/debug loader). Requester handshake:

---
 rtl/data_mem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one single-port word RAM between a CPU port (port 0) and a
//   DMA/debug loader port (port 1). One word transaction is in flight at a
//   time: IDLE -> ISSUE -> (WAIT for reads) -> DONE -> IDLE.
//   Port 0 has fixed priority; port 1 is forced through after STARVE_MAX
//   consecutive lost arbitrations.
//   Optional feature macro: DMEM_ARB_STATS_EN adds saturating per-port
//   grant counters gnt_cnt0/gnt_cnt1.
module data_mem_arbiter #(
  parameter int AW         = 5,
  parameter int DEPTH      = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [31:0]   wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata1,
  output logic          ack0,
  output logic [31:0]   rdata0,
  output logic          err0,
  output logic          ack1,
  output logic [31:0]   rdata1,
  output logic          err1,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [31:0]   mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   gnt_cnt0,
  output logic [15:0]   gnt_cnt1
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  localparam logic [AW:0] DEPTH_LIM  = DEPTH[AW:0];
  localparam logic [2:0]  LAT_LIM    = MEM_LAT[2:0];
  localparam logic [3:0]  STARVE_LIM = STARVE_MAX[3:0];

  state_e        state_q;
  logic          gnt_q;     // granted port id: 0 or 1
  logic          we_q;
  logic          oor_q;     // latched address is out of range
  logic [2:0]    lat_q;     // read latency counter while in WAIT
  logic [3:0]    starve_q;
  logic [3:0]    starve_d;
  logic          gnt1_d;
  logic          sel_we;
  logic          oor_d;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;

  // Arbitration winner, starvation counter update and winner's request fields
  always_comb begin
    gnt1_d   = 1'b0;
    starve_d = starve_q;
    if (req1 && (!req0 || starve_q == STARVE_LIM)) begin
      gnt1_d   = 1'b1;
      starve_d = '0;
    end else if (req1) begin
      // Port 1 loses; the counter can never pass the limit because reaching
      // it forces a port 1 grant on the next arbitration.
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = '0;
    end
    sel_we    = gnt1_d ? we1    : we0;
    sel_addr  = gnt1_d ? addr1  : addr0;
    sel_wdata = gnt1_d ? wdata1 : wdata0;
    oor_d     = ({1'b0, sel_addr} >= DEPTH_LIM);
  end

  // Transaction sequencer with registered memory strobes and requester responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      oor_q     <= 1'b0;
      lat_q     <= '0;
      starve_q  <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
    end else begin
      // Pulses and memory drive default to idle every cycle
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          starve_q <= starve_d;
          if (req0 || req1) begin
            gnt_q     <= gnt1_d;
            we_q      <= sel_we;
            oor_q     <= oor_d;
            // Memory side is registered so it is presented during ISSUE
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_wr    <= sel_we & ~oor_d;
            mem_rd    <= ~sel_we & ~oor_d;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (we_q) begin
            // Writes complete right after the strobe
            if (gnt_q) begin
              ack1 <= 1'b1;
              err1 <= oor_q;
            end else begin
              ack0 <= 1'b1;
              err0 <= oor_q;
            end
            state_q <= S_DONE;
          end else begin
            lat_q   <= 3'd1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_q == LAT_LIM) begin
            // mem_rdata is valid in this cycle; out-of-range reads return zero
            if (gnt_q) begin
              ack1   <= 1'b1;
              err1   <= oor_q;
              rdata1 <= oor_q ? '0 : mem_rdata;
            end else begin
              ack0   <= 1'b1;
              err0   <= oor_q;
              rdata0 <= oor_q ? '0 : mem_rdata;
            end
            state_q <= S_DONE;
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Per-port completed-transaction counters, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (ack0 && gnt_cnt0 != 16'hFFFF) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (ack1 && gnt_cnt1 != 16'hFFFF) gnt_cnt1 <= gnt_cnt1 + 16'd1;
    end
  end
`endif

endmodule
